// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//   AXI3-style slave in front of an on-chip byte-addressable SRAM of
//   2^ADDR_LENGTH bytes. Write and read channels are served by two independent
//   FSMs, each holding at most one outstanding burst.
//
// Ports
//   ACLK, ARESET         : clock, synchronous active-high reset
//   AW* / AWREADY        : write address channel (AWLOCK ignored)
//   W*  / WREADY         : write data channel (WID ignored)
//   B*  / BREADY         : write response channel
//   AR* / ARREADY        : read address channel (ARLOCK ignored)
//   R*  / RREADY         : read data channel
//
// Behaviour notes
//   - FIXED and INCR bursts are served. WRAP, the reserved burst type and any
//     SIZE wider than the data bus still run their LEN+1 beats, but writes are
//     dropped, reads return zero and the response is SLVERR.
//   - Burst length is set by LEN alone. A WLAST that disagrees with the beat
//     count only turns the final response into SLVERR.
//   - Address bits above ADDR_LENGTH are ignored, so the memory aliases.
//   - The memory is never cleared; reset only returns the FSMs to idle.
// -----------------------------------------------------------------------------
module axi_sram_slave #(
  parameter int WIDTH_ID    = 4,
  parameter int WIDTH_AD    = 32,
  parameter int WIDTH_DA    = 32,
  parameter int WIDTH_DS    = WIDTH_DA / 8,
  parameter int WIDTH_DSB   = $clog2(WIDTH_DS),
  parameter int ADDR_LENGTH = 12
) (
  input  logic                ACLK,
  input  logic                ARESET,
  // write address
  input  logic [WIDTH_ID-1:0] AWID,
  input  logic [WIDTH_AD-1:0] AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [1:0]          AWLOCK,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  // write data
  input  logic [WIDTH_ID-1:0] WID,
  input  logic [WIDTH_DA-1:0] WDATA,
  input  logic [WIDTH_DS-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  // write response
  output logic [WIDTH_ID-1:0] BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  // read address
  input  logic [WIDTH_ID-1:0] ARID,
  input  logic [WIDTH_AD-1:0] ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [1:0]          ARLOCK,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  // read data
  output logic [WIDTH_ID-1:0] RID,
  output logic [WIDTH_DA-1:0] RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int         LP_IDX_W    = ADDR_LENGTH - WIDTH_DSB;
  localparam int         LP_DEPTH    = 1 << LP_IDX_W;
  localparam logic [2:0] LP_MAX_SIZE = 3'(WIDTH_DSB);
  localparam logic [1:0] LP_FIXED    = 2'b00;
  localparam logic [1:0] LP_INCR     = 2'b01;
  localparam logic [1:0] LP_OKAY     = 2'b00;
  localparam logic [1:0] LP_SLVERR   = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Address of the next beat: INCR aligns down to the transfer size and then
  // steps by one transfer; every other burst type keeps the address.
  function automatic logic [WIDTH_AD-1:0] f_next_addr(
    input logic [WIDTH_AD-1:0] addr,
    input logic [2:0]          size,
    input logic [1:0]          burst
  );
    logic [WIDTH_AD-1:0] step;
    step = WIDTH_AD'(1) << size;
    if (burst == LP_INCR) begin
      return (addr & ~(step - WIDTH_AD'(1))) + step;
    end
    return addr;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [WIDTH_DA-1:0] r_mem [LP_DEPTH];
  logic [WIDTH_DA-1:0] r_rdata;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_t            r_wstate;
  logic                r_awready;
  logic                r_wready;
  logic                r_bvalid;
  logic [WIDTH_ID-1:0] r_bid;
  logic [1:0]          r_bresp;
  logic [WIDTH_AD-1:0] r_waddr;
  logic [3:0]          r_wlen;
  logic [2:0]          r_wsize;
  logic [1:0]          r_wburst;
  logic [3:0]          r_wcnt;
  logic                r_werr;   // WLAST disagreed with the beat count
  logic                r_wbad;   // unsupported burst/size: drop data, SLVERR

  logic                w_aw_bad;
  logic                w_w_hs;
  logic                w_w_last;
  logic                w_w_mismatch;
  logic                w_wr_en;
  logic [LP_IDX_W-1:0] w_wr_idx;

  assign w_aw_bad     = ((AWBURST != LP_FIXED) && (AWBURST != LP_INCR)) ||
                        (AWSIZE > LP_MAX_SIZE);
  assign w_w_hs       = r_wready & WVALID;
  assign w_w_last     = (r_wcnt == r_wlen);
  assign w_w_mismatch = (WLAST != w_w_last);
  // The beat presented on the same edge as a reset is part of the abandoned
  // burst, so it must not reach the memory either.
  assign w_wr_en      = w_w_hs & ~r_wbad & ~ARESET;
  assign w_wr_idx     = r_waddr[ADDR_LENGTH-1:WIDTH_DSB];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= LP_OKAY;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wsize   <= '0;
      r_wburst  <= '0;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
      r_wbad    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (AWVALID && r_awready) begin
            r_bid     <= AWID;
            r_waddr   <= AWADDR;
            r_wlen    <= AWLEN;
            r_wsize   <= AWSIZE;
            r_wburst  <= AWBURST;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_wbad    <= w_aw_bad;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            if (w_w_mismatch) begin
              r_werr <= 1'b1;
            end
            if (w_w_last) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              // Fold in this beat's mismatch too; r_werr only updates now.
              r_bresp  <= (r_werr || w_w_mismatch || r_wbad) ? LP_SLVERR : LP_OKAY;
              r_wstate <= W_RESP;
            end else begin
              r_wcnt  <= r_wcnt + 4'd1;
              r_waddr <= f_next_addr(r_waddr, r_wsize, r_wburst);
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: begin
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  // Byte-lane write; the memory keeps no reset so it maps onto block RAM.
  always_ff @(posedge ACLK) begin
    if (w_wr_en) begin
      for (int i = 0; i < WIDTH_DS; i++) begin
        if (WSTRB[i]) begin
          r_mem[w_wr_idx][i*8 +: 8] <= WDATA[i*8 +: 8];
        end
      end
    end
  end

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BID     = r_bid;
  assign BRESP   = r_bresp;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_t            r_rstate;
  logic                r_arready;
  logic                r_rvalid;
  logic                r_rlast;
  logic [WIDTH_ID-1:0] r_rid;
  logic [1:0]          r_rresp;
  logic [WIDTH_AD-1:0] r_raddr;
  logic [3:0]          r_rlen;
  logic [2:0]          r_rsize;
  logic [1:0]          r_rburst;
  logic [3:0]          r_rcnt;
  logic                r_rbad;

  logic                w_ar_bad;
  logic                w_ar_hs;
  logic                w_r_hs;
  logic [WIDTH_AD-1:0] w_rd_next_addr;
  logic                w_rd_en;
  logic [LP_IDX_W-1:0] w_rd_idx;

  assign w_ar_bad       = ((ARBURST != LP_FIXED) && (ARBURST != LP_INCR)) ||
                          (ARSIZE > LP_MAX_SIZE);
  assign w_ar_hs        = ARVALID & r_arready;
  assign w_r_hs         = r_rvalid & RREADY;
  assign w_rd_next_addr = f_next_addr(r_raddr, r_rsize, r_rburst);
  // The registered read is issued one cycle ahead: at the AR handshake for the
  // first beat, at each accepted beat for the following one. While the master
  // stalls nothing is fetched, so RDATA holds.
  assign w_rd_en        = w_ar_hs | (w_r_hs & ~r_rlast);
  assign w_rd_idx       = w_ar_hs ? ARADDR[ADDR_LENGTH-1:WIDTH_DSB]
                                  : w_rd_next_addr[ADDR_LENGTH-1:WIDTH_DSB];

  // Separate from the write block so that a same-word write on the same edge
  // is seen only by later reads (read-first).
  always_ff @(posedge ACLK) begin
    if (w_rd_en) begin
      r_rdata <= r_mem[w_rd_idx];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rresp   <= LP_OKAY;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rsize   <= '0;
      r_rburst  <= '0;
      r_rcnt    <= '0;
      r_rbad    <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_rid     <= ARID;
            r_raddr   <= ARADDR;
            r_rlen    <= ARLEN;
            r_rsize   <= ARSIZE;
            r_rburst  <= ARBURST;
            r_rcnt    <= '0;
            r_rbad    <= w_ar_bad;
            r_rresp   <= w_ar_bad ? LP_SLVERR : LP_OKAY;
            r_rlast   <= (ARLEN == 4'd0);
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_rcnt  <= r_rcnt + 4'd1;
              r_rlast <= ((r_rcnt + 4'd1) == r_rlen);
              r_raddr <= w_rd_next_addr;
            end
          end
        end
      endcase
    end
  end

  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RLAST   = r_rlast;
  assign RID     = r_rid;
  assign RRESP   = r_rresp;
  // Unsupported bursts read as zero; outside a beat the bus is parked at zero.
  assign RDATA   = (r_rvalid && !r_rbad) ? r_rdata : '0;

  // Inputs the protocol defines but this slave has no use for.
  logic w_unused;
  assign w_unused = ^{AWLOCK, ARLOCK, WID};

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [1:0]  AWLOCK;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [1:0]  ARLOCK;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  axi_sram_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWLOCK(AWLOCK), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARLOCK(ARLOCK), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  localparam int TMO = 50;

  typedef struct {
    logic             wr;
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0][31:0] d;      // write data, or expected read data
    logic [3:0]       strb;
    int               early;  // beat carrying a wrong WLAST, -1 for none
    logic             stall;  // read: hold RREADY low one cycle per beat
    logic [1:0]       resp;   // expected BRESP / RRESP
  } vec_t;

  localparam int NV = 26;
  vec_t tv [NV];

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [3:0] strb, input int early, input logic stall,
                              input logic [1:0] resp);
    vec_t t;
    t.wr = wr; t.id = id; t.addr = addr; t.len = len; t.size = size; t.burst = burst;
    t.d[0] = d0; t.d[1] = d1; t.d[2] = d2; t.d[3] = d3;
    t.strb = strb; t.early = early; t.stall = stall; t.resp = resp;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    for (int k = 0; k < TMO && !AWREADY; k++) @(negedge ACLK);
    chk("awready_wait", 32'(AWREADY), 32'd1);
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last);
    WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
    for (int k = 0; k < TMO && !WREADY; k++) @(negedge ACLK);
    chk("wready_wait", 32'(WREADY), 32'd1);
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic recv_b(input string nm, input logic [3:0] id, input logic [1:0] resp);
    for (int k = 0; k < TMO && !BVALID; k++) @(negedge ACLK);
    chk({nm, " bvalid"}, 32'(BVALID), 32'd1);
    chk({nm, " bid"},    32'(BID),    32'(id));
    chk({nm, " bresp"},  32'(BRESP),  32'(resp));
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    for (int k = 0; k < TMO && !ARREADY; k++) @(negedge ACLK);
    chk("arready_wait", 32'(ARREADY), 32'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
  endtask

  task automatic write_txn(input string nm, input vec_t t);
    send_aw(t.id, t.addr, t.len, t.size, t.burst);
    for (int b = 0; b <= int'(t.len); b++)
      send_w(t.d[b], t.strb, (b == int'(t.len)) ^ (b == t.early));
    recv_b(nm, t.id, t.resp);
  endtask

  task automatic read_txn(input string nm, input vec_t t);
    send_ar(t.id, t.addr, t.len, t.size, t.burst);
    chk({nm, " rvalid_latency"}, 32'(RVALID), 32'd1);
    for (int b = 0; b <= int'(t.len); b++) begin
      for (int k = 0; k < TMO && !RVALID; k++) @(negedge ACLK);
      chk($sformatf("%s beat%0d rdata", nm, b), RDATA, t.d[b]);
      chk($sformatf("%s beat%0d rresp", nm, b), 32'(RRESP), 32'(t.resp));
      chk($sformatf("%s beat%0d rlast", nm, b), 32'(RLAST), 32'(b == int'(t.len)));
      chk($sformatf("%s beat%0d rid", nm, b),   32'(RID),   32'(t.id));
      if (t.stall) begin
        @(negedge ACLK);
        chk($sformatf("%s beat%0d stall_rvalid", nm, b), 32'(RVALID), 32'd1);
        chk($sformatf("%s beat%0d stall_rdata", nm, b),  RDATA, t.d[b]);
      end
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
    end
    chk({nm, " rvalid_end"}, 32'(RVALID), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    int   seen_b;

    //            wr id   addr       len s burst d0            d1            d2            d3            strb early stall resp
    tv[0]  = mk(1, 1,  32'h000,   0, 2, 2'b01, 32'hA5A5_0001, 0,            0,            0,            4'hF, -1, 0, 2'b00);
    tv[1]  = mk(0, 1,  32'h000,   0, 2, 2'b01, 32'hA5A5_0001, 0,            0,            0,            4'h0, -1, 0, 2'b00);
    tv[2]  = mk(1, 2,  32'h030,   3, 2, 2'b01, 1,             2,            3,            4,            4'hF, -1, 0, 2'b00);
    tv[3]  = mk(0, 2,  32'h030,   3, 2, 2'b01, 1,             2,            3,            4,            4'h0, -1, 1, 2'b00);
    tv[4]  = mk(1, 3,  32'h040,   0, 2, 2'b01, 32'h1122_3344, 0,            0,            0,            4'hF, -1, 0, 2'b00);
    tv[5]  = mk(1, 4,  32'h041,   0, 0, 2'b01, 32'h1234_EE56, 0,            0,            0,            4'h2, -1, 0, 2'b00);
    tv[6]  = mk(0, 4,  32'h040,   0, 2, 2'b01, 32'h1122_EE44, 0,            0,            0,            4'h0, -1, 0, 2'b00);
    tv[7]  = mk(1, 5,  32'h030,   3, 2, 2'b10, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004, 4'hF, -1, 0, 2'b10);
    tv[8]  = mk(0, 5,  32'h030,   3, 2, 2'b01, 1,             2,            3,            4,            4'h0, -1, 0, 2'b00);
    tv[9]  = mk(0, 6,  32'h030,   1, 2, 2'b10, 0,             0,            0,            0,            4'h0, -1, 0, 2'b10);
    tv[10] = mk(1, 7,  32'h050,   3, 2, 2'b01, 32'h10,        32'h20,       32'h30,       32'h40,       4'hF,  1, 0, 2'b10);
    tv[11] = mk(0, 7,  32'h050,   3, 2, 2'b01, 32'h10,        32'h20,       32'h30,       32'h40,       4'h0, -1, 0, 2'b00);
    tv[12] = mk(1, 8,  32'h1000,  0, 2, 2'b01, 32'hCAFE_F00D, 0,            0,            0,            4'hF, -1, 0, 2'b00);
    tv[13] = mk(0, 8,  32'h000,   0, 2, 2'b01, 32'hCAFE_F00D, 0,            0,            0,            4'h0, -1, 0, 2'b00);
    tv[14] = mk(0, 9,  32'h1030,  0, 2, 2'b01, 1,             0,            0,            0,            4'h0, -1, 0, 2'b00);
    tv[15] = mk(1, 9,  32'h060,   2, 2, 2'b00, 32'h61,        32'h62,       32'h63,       0,            4'hF, -1, 0, 2'b00);
    tv[16] = mk(0, 9,  32'h060,   1, 2, 2'b00, 32'h63,        32'h63,       0,            0,            4'h0, -1, 0, 2'b00);
    tv[17] = mk(0, 9,  32'h060,   0, 2, 2'b01, 32'h63,        0,            0,            0,            4'h0, -1, 0, 2'b00);
    tv[18] = mk(1, 10, 32'h070,   0, 2, 2'b01, 32'h7777_7777, 0,            0,            0,            4'hF, -1, 0, 2'b00);
    tv[19] = mk(1, 10, 32'h070,   0, 3, 2'b01, 32'h8888_8888, 0,            0,            0,            4'hF, -1, 0, 2'b10);
    tv[20] = mk(0, 10, 32'h070,   0, 2, 2'b01, 32'h7777_7777, 0,            0,            0,            4'h0, -1, 0, 2'b00);
    tv[21] = mk(0, 10, 32'h070,   0, 3, 2'b01, 0,             0,            0,            0,            4'h0, -1, 0, 2'b10);
    tv[22] = mk(1, 11, 32'h092,   1, 2, 2'b01, 32'h9A,        32'h9B,       0,            0,            4'hF, -1, 0, 2'b00);
    tv[23] = mk(0, 11, 32'h090,   1, 2, 2'b01, 32'h9A,        32'h9B,       0,            0,            4'h0, -1, 0, 2'b00);
    tv[24] = mk(1, 12, 32'h0A2,   1, 0, 2'b01, 32'h1111_1111, 32'h2222_2222, 0,            0,            4'hF, -1, 0, 2'b00);
    tv[25] = mk(0, 12, 32'h0A0,   0, 2, 2'b01, 32'h2222_2222, 0,            0,            0,            4'h0, -1, 0, 2'b00);

    ARESET = 1'b1;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWLOCK = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
    WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARLOCK = 0; ARSIZE = 0; ARBURST = 0; ARVALID = 0; RREADY = 0;

    // Reset state
    repeat (3) @(negedge ACLK);
    chk("rst awready", 32'(AWREADY), 32'd0);
    chk("rst wready",  32'(WREADY),  32'd0);
    chk("rst bvalid",  32'(BVALID),  32'd0);
    chk("rst arready", 32'(ARREADY), 32'd0);
    chk("rst rvalid",  32'(RVALID),  32'd0);
    chk("rst rlast",   32'(RLAST),   32'd0);
    chk("rst ids",     32'({BID, RID}), 32'd0);
    chk("rst resps",   32'({BRESP, RRESP}), 32'd0);
    chk("rst rdata",   RDATA, 32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst awready", 32'(AWREADY), 32'd1);
    chk("post_rst arready", 32'(ARREADY), 32'd1);

    // Directed vectors
    for (int v = 0; v < NV; v++) begin
      t = tv[v];
      if (t.wr) write_txn($sformatf("vec%0d wr", v), t);
      else      read_txn($sformatf("vec%0d rd", v), t);
      $display("vec %0d %s id=%0d addr=%h len=%0d size=%0d burst=%0d done", v,
               t.wr ? "WR" : "RD", t.id, t.addr, t.len, t.size, t.burst);
    end

    // BREADY held low: response holds, no new AW accepted
    send_aw(4'hA, 32'h0E0, 0, 2, 2'b01);
    send_w(32'hE0E0_E0E0, 4'hF, 1'b1);
    for (int k = 0; k < TMO && !BVALID; k++) @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = 32'h0F0; AWID = 4'h3;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bhold c%0d bvalid", c),  32'(BVALID),  32'd1);
      chk($sformatf("bhold c%0d bid", c),     32'(BID),     32'hA);
      chk($sformatf("bhold c%0d bresp", c),   32'(BRESP),   32'd0);
      chk($sformatf("bhold c%0d awready", c), 32'(AWREADY), 32'd0);
      @(negedge ACLK);
    end
    AWVALID = 1'b0; BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("bhold release bvalid",  32'(BVALID),  32'd0);
    chk("bhold release awready", 32'(AWREADY), 32'd1);
    chk("bhold release wready",  32'(WREADY),  32'd0);
    $display("seq bready_hold done");

    // Reset during beat 2 of a 4-beat write
    send_aw(4'hB, 32'h0B0, 3, 2, 2'b01);
    send_w(32'hB0B0_0000, 4'hF, 1'b0);
    send_w(32'hB0B0_0001, 4'hF, 1'b0);
    WDATA = 32'hBAD0_0002; WSTRB = 4'hF; WVALID = 1'b1; ARESET = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    chk("midrst awready", 32'(AWREADY), 32'd0);
    chk("midrst wready",  32'(WREADY),  32'd0);
    chk("midrst arready", 32'(ARREADY), 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("midrst release awready", 32'(AWREADY), 32'd1);
    chk("midrst release arready", 32'(ARREADY), 32'd1);
    seen_b = 0;
    for (int c = 0; c < 10; c++) begin
      if (BVALID) seen_b++;
      @(negedge ACLK);
    end
    chk("midrst no_bvalid", 32'(seen_b), 32'd0);
    read_txn("midrst persist", mk(0, 4'hB, 32'h0B0, 1, 2, 2'b01, 32'hB0B0_0000, 32'hB0B0_0001,
                                  0, 0, 4'h0, -1, 0, 2'b00));
    read_txn("midrst old_data", mk(0, 4'h2, 32'h030, 0, 2, 2'b01, 1, 0, 0, 0, 4'h0, -1, 0, 2'b00));
    $display("seq reset_mid_burst done");

    // Read fetched on the same edge as a write to the same word
    write_txn("coll init", mk(1, 4'hC, 32'h0C0, 0, 2, 2'b01, 32'h0000_C0C0, 0, 0, 0, 4'hF, -1, 0, 2'b00));
    send_aw(4'hC, 32'h0C0, 0, 2, 2'b01);
    WDATA = 32'h1111_C0C1; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    ARID = 4'hD; ARADDR = 32'h0C0; ARLEN = 0; ARSIZE = 2; ARBURST = 2'b01; ARVALID = 1'b1;
    chk("coll wready",  32'(WREADY),  32'd1);
    chk("coll arready", 32'(ARREADY), 32'd1);
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
    chk("coll rvalid", 32'(RVALID), 32'd1);
    chk("coll rdata_old", RDATA, 32'h0000_C0C0);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    recv_b("coll", 4'hC, 2'b00);
    read_txn("coll after", mk(0, 4'hE, 32'h0C0, 0, 2, 2'b01, 32'h1111_C0C1, 0, 0, 0, 4'h0, -1, 0, 2'b00));
    $display("seq collision done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter WIDTH_ID, default 4, meaning AXI ID width.
REQ-002 SHALL have parameter WIDTH_AD, default 32, meaning address width.
REQ-003 SHALL have parameter WIDTH_DA, default 32, meaning data width, 8/16/32/64 only.
REQ-004 SHALL have parameter WIDTH_DS, default WIDTH_DA/8, meaning strobe width; WIDTH_DSB, default clogb2(WIDTH_DS), meaning byte-lane address bits.
REQ-005 SHALL have parameter ADDR_LENGTH, default 12, meaning memory size of 2^ADDR_LENGTH bytes.
REQ-006 SHALL have ports ACLK (in, 1, clock) and ARESET (in, 1, reset); one clock; reset is synchronous and active-high.
REQ-007 SHALL have write-address ports: AWID in WIDTH_ID; AWADDR in WIDTH_AD; AWLEN in 4; AWLOCK in 2 (ignored); AWSIZE in 3; AWBURST in 2; AWVALID in 1; AWREADY out 1.
REQ-008 SHALL have write-data ports: WID in WIDTH_ID (ignored); WDATA in WIDTH_DA; WSTRB in WIDTH_DS; WLAST in 1; WVALID in 1; WREADY out 1.
REQ-009 SHALL have write-response ports: BID out WIDTH_ID; BRESP out 2; BVALID out 1; BREADY in 1.
REQ-010 SHALL have read-address ports: ARID, ARADDR, ARLEN, ARLOCK (ignored), ARSIZE, ARBURST, ARVALID in, with AW widths; ARREADY out 1.
REQ-011 SHALL have read-data ports: RID out WIDTH_ID; RDATA out WIDTH_DA; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1.

Function
REQ-012 SHALL implement write and read paths as independent FSMs, one outstanding transaction each.
REQ-013 Write FSM SHALL have states W_IDLE (AWREADY=1), W_DATA (WREADY=1), W_RESP (BVALID=1); all other ready/valid low.
REQ-014 W_IDLE: on AWVALID&AWREADY, latch AWID/AWADDR/AWLEN/AWSIZE/AWBURST, clear beat count and error flag, go W_DATA next cycle.
REQ-015 W_DATA: each WVALID&WREADY SHALL write WDATA byte lanes with WSTRB=1 into word addr[ADDR_LENGTH-1:WIDTH_DSB]; lanes with WSTRB=0 unchanged.
REQ-016 W_DATA: beat count == latched LEN on a handshake SHALL go W_RESP; WLAST disagreeing with last-beat status on any beat SHALL set error flag; burst length governed by LEN only.
REQ-017 W_RESP: BID=latched ID, BRESP=2'b10 if error flag else 2'b00; hold until BREADY, then W_IDLE.
REQ-018 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (RVALID=1).
REQ-019 R_IDLE: on ARVALID&ARREADY, latch request and go R_DATA; RVALID SHALL assert on the cycle after AR handshake, RDATA valid that cycle.
REQ-020 R_DATA: RID=latched ID, RLAST=1 only on beat LEN; RDATA/RRESP/RLAST stable while RVALID&!RREADY; on RREADY advance beat; after last beat return R_IDLE.
REQ-021 Next address SHALL be (addr & ~((1<<SIZE)-1)) + (1<<SIZE) for INCR (2'b01); unchanged for FIXED (2'b00).
REQ-022 Burst WRAP/reserved or SIZE > WIDTH_DSB SHALL be accepted, complete LEN+1 beats, discard writes, return RDATA=0, respond SLVERR (2'b10).
REQ-023 Address bits above ADDR_LENGTH SHALL be ignored (memory aliases); word index wraps modulo 2^(ADDR_LENGTH-WIDTH_DSB).
REQ-024 Read returns full data word regardless of SIZE; lane selection is the master's job.
REQ-025 Read beat fetched in same cycle as a write to same word SHALL return pre-write data.

Reset
REQ-026 While ARESET=1: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BID, BRESP, RID, RRESP, RDATA = 0; FSMs to W_IDLE/R_IDLE.
REQ-027 Reset asserted mid-burst SHALL abandon the transaction with no response; memory contents SHALL NOT be cleared or initialised by reset.
REQ-028 First cycle after ARESET falls, AWREADY=1 and ARREADY=1.

Verification
REQ-029 Single write id=1 addr=0x0 LEN=0 SIZE=2 INCR WDATA=0xA5A5_0001 WSTRB=0xF -> BID=1 BRESP=00; read same -> RDATA=0xA5A5_0001 RLAST=1 RRESP=00.
REQ-030 INCR LEN=3 SIZE=2 write at 0x30 data 1..4, read back with RREADY toggling every other cycle -> data 1,2,3,4, RLAST on 4th only, RDATA stable during stalls.
REQ-031 Narrow write SIZE=0 addr 0x41 WSTRB=0x2 data 0xXXXX_EEXX over word 0x1122_3344 -> read 0x1122_EE44.
REQ-032 WRAP burst or WLAST early on beat 1 of LEN=3 -> BRESP=10, memory unchanged for WRAP; read WRAP -> RDATA=0, RRESP=10 each beat.
REQ-033 Write addr 0x1000 (ADDR_LENGTH=12) -> read 0x0 returns written data; BREADY held low 5 cycles -> BVALID/BID stable, no new AW accepted.
REQ-034 ARESET pulsed during W_DATA beat 2 -> BVALID never asserts, AWREADY=1 the cycle after release, beats already written persist.
